// File: rtl/fixmul_seq_if.sv
// Operand/result handshake bundle for the sequential fixed-point multiplier.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface fixmul_seq_if #(
    parameter int DW = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     a;
    logic [DW-1:0]     b;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   z;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  z
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output z
    );
endinterface

// File: rtl/fixmul_seq.sv
// Sequential signed fixed-point multiplier: sign-magnitude radix-2 shift-add over DW cycles.
// Produces the exact 2*DW-bit product with 2*FW fraction bits; rounding happens downstream.
module fixmul_seq #(
    parameter int DW = 8,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          clear,
    fixmul_seq_if.slave   bus,
    output logic [1:0]    dbg_state
);

    if (DW < 2 || FW < 0 || FW >= DW) begin : g_bad_params
        $error("fixmul_seq: requires DW >= 2 and 0 <= FW < DW");
    end

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic [2*DW-1:0]   mcand_q,     mcand_d;
    logic [DW-1:0]     mplier_q,    mplier_d;
    logic              sign_q,      sign_d;
    logic [2*DW-1:0]   acc_q,       acc_d;
    logic [2*DW-1:0]   z_q,         z_d;
    logic              out_valid_q, out_valid_d;

    logic [DW-1:0]     mag_a;
    logic [DW-1:0]     mag_b;
    logic [2*DW-1:0]   acc_sum;
    logic              accept;

    // Magnitudes are unsigned DW-bit, so -2^(DW-1) becomes 2^(DW-1) without overflow.
    assign mag_a = bus.a[DW-1] ? (~bus.a + 1'b1) : bus.a;
    assign mag_b = bus.b[DW-1] ? (~bus.b + 1'b1) : bus.b;

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
    assign dbg_state     = state_q;

    assign accept  = bus.in_valid && (state_q == S_IDLE) && !clear;
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        sign_d      = sign_q;
        acc_d       = acc_q;
        z_d         = z_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mcand_d  = {{DW{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    sign_d   = bus.a[DW-1] ^ bus.b[DW-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                // mcand holds |a|<<i and mplier holds |b|>>i at iteration i.
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    z_d         = sign_q ? (~acc_sum + 1'b1) : acc_sum;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                cnt_d       = '0;
            end
        endcase

        // Abort wins over every handshake; z deliberately keeps its last value.
        if (clear) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            sign_q      <= 1'b0;
            acc_q       <= '0;
            z_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            sign_q      <= sign_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fixmul_seq.sv
// Bench for fixmul_seq: directed corner cases, backpressure, clear, reset, and random traffic
// against an integer-multiply reference model.
module tb_fixmul_seq;

  localparam int DW = 8;
  localparam int FW = 4;
  localparam int TIMEOUT = 64;

  logic clk;
  logic nreset;
  logic clear;
  logic [1:0] dbg_state;

  int vectors;
  int miscompares;

  logic [2*DW-1:0] exp_q[$];

  fixmul_seq_if #(.DW(DW)) bus ();

  fixmul_seq #(.DW(DW), .FW(FW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .clear     (clear),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2*DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int pa;
    int pb;
    int p;
    pa = $signed(a);
    pb = $signed(b);
    p  = pa * pb;
    return p[2*DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_operand();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'h00;
      3: return 8'hFF;
      default: return DW'($urandom);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    clear         = 1'b0;
  endtask

  // Presents one operand pair and returns right after the accepting edge.
  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, output bit ok);
    int n;
    n = 0;
    while (!bus.in_ready && n < TIMEOUT) begin
      tick();
      n++;
    end
    ok = bus.in_ready;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    tick();
    bus.in_valid = 1'b0;
    bus.a = DW'($urandom);
    bus.b = DW'($urandom);
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < TIMEOUT) begin
      tick();
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b0;
    drive_idle();
    #2;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.z !== '0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: out_valid=%b z=%h in_ready=%b, want 0 0000 1",
               bus.out_valid, bus.z, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.a = 8'h33;
    bus.b = 8'h44;
    repeat (3) tick();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ignores_handshake: in_ready=%b out_valid=%b, want 1 0",
               bus.in_ready, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int cyc;
    issue(8'h18, 8'h20, ok);
    wait_out(cyc);
    vectors++;
    if (cyc !== DW) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d edges after accept, want %0d", cyc, DW);
    end
    vectors++;
    if (bus.z !== 16'h0300 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: z=%h in_ready=%b, want 0300 0", bus.z, bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.z !== 16'h0300) begin
      miscompares++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b z=%h, want 0 1 0300",
               bus.out_valid, bus.in_ready, bus.z);
    end
  endtask

  task automatic test_corners();
    logic [DW-1:0] ta[5];
    logic [DW-1:0] tb[5];
    logic [2*DW-1:0] tz[5];
    bit ok;
    int cyc;
    ta = '{8'h80, 8'h80, 8'h00, 8'hF0, 8'hFF};
    tb = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'hFF};
    tz = '{16'h4000, 16'hC080, 16'h0000, 16'h0000, 16'h0001};
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i], ok);
      wait_out(cyc);
      vectors++;
      if (bus.z !== tz[i] || bus.z !== model(ta[i], tb[i]) || cyc !== DW) begin
        miscompares++;
        $display("FAIL corner_%0d: a=%h b=%h z=%h lat=%0d, want %h lat %0d",
                 i, ta[i], tb[i], bus.z, cyc, tz[i], DW);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    logic [2*DW-1:0] held;
    bus.out_ready = 1'b0;
    issue(8'hE8, 8'h31, ok);
    wait_out(cyc);
    held = bus.z;
    vectors++;
    if (held !== model(8'hE8, 8'h31)) begin
      miscompares++;
      $display("FAIL bp_result: z=%h, want %h", held, model(8'hE8, 8'h31));
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a = DW'($urandom);
      bus.b = DW'($urandom);
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.z !== held || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: out_valid=%b z=%h in_ready=%b, want 1 %h 0",
                 i, bus.out_valid, bus.z, bus.in_ready, held);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.z !== held) begin
      miscompares++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b z=%h, want 0 1 %h",
               bus.out_valid, bus.in_ready, bus.z, held);
    end
  endtask

  task automatic test_clear();
    bit ok;
    bit rose;
    int cyc;
    logic [2*DW-1:0] prev_z;
    prev_z = bus.z;
    issue(8'h5A, 8'hC3, ok);
    tick();
    tick();
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 8'h11;
    bus.b = 8'h22;
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.z !== prev_z) begin
      miscompares++;
      $display("FAIL clear_abort: in_ready=%b out_valid=%b z=%h, want 1 0 %h",
               bus.in_ready, bus.out_valid, bus.z, prev_z);
    end
    rose = 1'b0;
    for (int i = 0; i < DW + 2; i++) begin
      tick();
      if (bus.out_valid || !bus.in_ready) rose = 1'b1;
    end
    vectors++;
    if (rose !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_no_accept: activity seen=%b after clear, want 0", rose);
    end
    issue(8'h9C, 8'h27, ok);
    wait_out(cyc);
    vectors++;
    if (bus.z !== model(8'h9C, 8'h27) || cyc !== DW) begin
      miscompares++;
      $display("FAIL clear_recover: z=%h lat=%0d, want %h lat %0d",
               bus.z, cyc, model(8'h9C, 8'h27), DW);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int cyc;
    issue(8'h7F, 8'h7F, ok);
    repeat (3) tick();
    nreset = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.z !== '0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_busy: out_valid=%b z=%h in_ready=%b, want 0 0000 1",
               bus.out_valid, bus.z, bus.in_ready);
    end
    tick();
    nreset = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    issue(8'hC0, 8'h40, ok);
    wait_out(cyc);
    vectors++;
    if (bus.z !== model(8'hC0, 8'h40) || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_done: z=%h out_valid=%b, want %h 1",
               bus.z, bus.out_valid, model(8'hC0, 8'h40));
    end
    tick();
    nreset = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.z !== '0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_done: out_valid=%b z=%h in_ready=%b, want 0 0000 1",
               bus.out_valid, bus.z, bus.in_ready);
    end
    tick();
    nreset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    localparam int N = 150;
    int sent;
    int recv;
    int lat;
    int cycles;
    bit waiting;
    bit ov;
    bit ordy;
    bit acc;
    logic [2*DW-1:0] zs;
    logic [2*DW-1:0] e;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    sent = 0;
    recv = 0;
    lat = 0;
    cycles = 0;
    waiting = 1'b0;
    while (recv < N && cycles < N * (DW + 30)) begin
      acc = 1'b0;
      if (bus.in_ready && sent < N) begin
        ra = rand_operand();
        rb = rand_operand();
        bus.in_valid = 1'b1;
        bus.a = ra;
        bus.b = rb;
        exp_q.push_back(model(ra, rb));
        sent++;
        acc = 1'b1;
      end else begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.a = DW'($urandom);
        bus.b = DW'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 99) < 55);
      ov = bus.out_valid;
      ordy = bus.out_ready;
      zs = bus.z;
      tick();
      cycles++;
      if (waiting) lat++;
      if (acc) begin
        waiting = 1'b1;
        lat = 0;
      end
      if (waiting && bus.out_valid) begin
        waiting = 1'b0;
        vectors++;
        if (lat !== DW) begin
          miscompares++;
          $display("FAIL rand_latency: op %0d out_valid %0d edges after accept, want %0d",
                   sent, lat, DW);
        end
      end
      if (ov && ordy) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        recv++;
        vectors++;
        if (zs !== e) begin
          miscompares++;
          $display("FAIL rand_result_%0d: z=%h, want %h", recv, zs, e);
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    vectors++;
    if (recv !== N || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL rand_drain: received %0d results (%0d pending), want %0d (0 pending)",
               recv, exp_q.size(), N);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_clear();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
